// File: rtl/poly_ram_loader.sv
// Streams one polynomial of DEPTH coefficients into a single-port RAM,
// reducing each coefficient into [0, Q) and flagging values that are too large.
module poly_ram_loader #(
    parameter int DEPTH = 128,
    parameter int Q     = 3329
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        ram_en,
    output logic        ram_we,
    output logic [6:0]  ram_addr,
    output logic [15:0] ram_di,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [6:0]    ram_addr_q, ram_addr_d;
    logic [15:0]   ram_di_q, ram_di_d;

    logic          accept;
    logic [16:0]   data_ext;
    logic [15:0]   reduced;
    logic          out_of_range;

    // Inputs are assumed below 2Q; anything larger is zeroed and flagged.
    always_comb begin
        data_ext     = {1'b0, s_data};
        reduced      = s_data;
        out_of_range = 1'b0;
        if (data_ext >= 17'(2 * Q)) begin
            reduced      = '0;
            out_of_range = 1'b1;
        end else if (data_ext >= 17'(Q)) begin
            reduced = s_data - 16'(Q);
        end
    end

    assign accept = (state_q == LOAD) && s_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = 7'(cnt_q);
                    ram_di_d   = reduced;
                    cnt_d      = cnt_q + AW'(1);
                    if (out_of_range) begin
                        err_d = 1'b1;
                    end
                    // Final write lands in the same cycle as DONE.
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
        end
    end

    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;

endmodule

// File: tb/tb_poly_ram_loader.sv
// Directed bench for poly_ram_loader: reduction table, full loads, stalls,
// ignored start pulses and a reset abort, with a behavioural RAM for readback.
module tb_poly_ram_loader;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, ram_en, ram_we, busy, done, err;
    logic [6:0]  ram_addr;
    logic [15:0] ram_di;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [DEPTH];

    poly_ram_loader #(.DEPTH(DEPTH), .Q(3329)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_di;
    end

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_di;
        logic        exp_err;
    } red_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one valid beat, then check the write it produces one cycle later.
    task automatic beat(input logic [15:0] d, input logic [15:0] exp_di,
                        input logic exp_err, input int exp_addr, input logic exp_done);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        check("ram_we", ram_we, 1);
        check("ram_en", ram_en, 1);
        check("ram_addr", ram_addr, exp_addr);
        check("ram_di", ram_di, exp_di);
        check("err", err, exp_err);
        check("done", done, exp_done);
        $display("beat addr=%0d data=%0d di=%0d err=%0b done=%0b", exp_addr, d, ram_di, err, done);
    endtask

    task automatic gap(input int exp_addr, input logic [15:0] exp_di);
        s_valid = 1'b0;
        s_data  = 16'hBEEF;
        @(negedge clk);
        check("gap_we", ram_we, 0);
        check("gap_en", ram_en, 0);
        check("gap_addr_hold", ram_addr, exp_addr);
        check("gap_di_hold", ram_di, exp_di);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_ready", s_ready, 1);
        check("load_err_clr", err, 0);
        check("load_we", ram_we, 0);
    endtask

    task automatic expect_idle(input logic exp_err);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ready", s_ready, 0);
        check("idle_err", err, exp_err);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", s_ready, 0);
        check("rst_en", ram_en, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_di", ram_di, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'hFFFF;
    endtask

    task automatic check_mem_index();
        for (int i = 0; i < DEPTH; i++) check("readback", mem[i], i);
    endtask

    // Full load of data=i; stall inserts two gaps after every even beat,
    // poke_start pulses start mid-load and in the DONE cycle.
    task automatic full_load(input bit stall, input bit poke_start);
        clear_mem();
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            start = (poke_start && i == 50);
            beat(16'(i), 16'(i), 1'b0, i, i == DEPTH - 1);
            start = 1'b0;
            if (i == DEPTH - 1) begin
                check("done_ready", s_ready, 0);
                check("done_busy", busy, 1);
            end else if (stall && (i % 2 == 0)) begin
                gap(i, 16'(i));
                gap(i, 16'(i));
            end
        end
        start = poke_start;
        @(negedge clk);
        start = 1'b0;
        expect_idle(1'b0);
        check("post_done_we", ram_we, 0);
        @(negedge clk);
        expect_idle(1'b0);
        check_mem_index();
    endtask

    red_vec_t red_tab [9];

    initial begin
        red_tab[0] = '{16'd0,     16'd0,    1'b0};
        red_tab[1] = '{16'd3328,  16'd3328, 1'b0};
        red_tab[2] = '{16'd3329,  16'd0,    1'b0};
        red_tab[3] = '{16'd6657,  16'd3328, 1'b0};
        red_tab[4] = '{16'd3330,  16'd1,    1'b0};
        red_tab[5] = '{16'd6656,  16'd3327, 1'b0};
        red_tab[6] = '{16'd6658,  16'd0,    1'b1};
        red_tab[7] = '{16'd100,   16'd100,  1'b1};
        red_tab[8] = '{16'd65535, 16'd0,    1'b1};

        // Reset state
        #2;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        $display("reset released, idle");

        // Back-to-back full load
        full_load(1'b0, 1'b0);
        $display("full load complete");

        // Reduction table, then fill the rest of the polynomial
        start_load();
        for (int i = 0; i < 9; i++) begin
            beat(red_tab[i].data, red_tab[i].exp_di, red_tab[i].exp_err, i, 1'b0);
        end
        for (int i = 9; i < DEPTH; i++) begin
            beat(16'd7, 16'd7, 1'b1, i, i == DEPTH - 1);
        end
        @(negedge clk);
        expect_idle(1'b1);
        @(negedge clk);
        expect_idle(1'b1);
        start_load();
        for (int i = 0; i < DEPTH; i++) begin
            beat(16'(i + 3329), 16'(i), 1'b0, i, i == DEPTH - 1);
        end
        @(negedge clk);
        expect_idle(1'b0);
        $display("reduction load complete");

        // Stalled load with ignored start pulses
        full_load(1'b1, 1'b1);
        $display("stalled load complete");

        // Reset abort after beat 40
        start_load();
        for (int i = 0; i <= 40; i++) begin
            beat((i == 20) ? 16'd7000 : 16'(i), (i == 20) ? 16'd0 : 16'(i),
                 i >= 20, i, 1'b0);
        end
        s_valid = 1'b1;
        s_data  = 16'd41;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        $display("reset abort checked");
        full_load(1'b0, 1'b0);
        $display("reload after abort complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/poly_ram_loader.md
POLY_RAM_LOADER -- requirements
Module: poly_ram_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning the number of coefficients per polynomial (RAM depth).
REQ-002 The block SHALL have parameter Q, default 3329, meaning the Kyber modulus used for input reduction.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: port clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin loading one polynomial.
REQ-006 s_valid  input  1  input coefficient valid.
REQ-007 s_data  input  16  input coefficient, unsigned.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 ram_en  output  1  RAM enable to the single-port 128x16 no-change RAM.
REQ-010 ram_we  output  1  RAM write enable.
REQ-011 ram_addr  output  7  RAM address.
REQ-012 ram_di  output  16  RAM write data.
REQ-013 busy  output  1  high while not IDLE.
REQ-014 done  output  1  one-cycle pulse when the last write has been issued.
REQ-015 err  output  1  sticky flag: at least one out-of-range coefficient in the current load.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, DONE; busy = (state != IDLE).
REQ-017 IDLE -> LOAD on start=1; start SHALL be ignored in LOAD and DONE.
REQ-018 Entering LOAD SHALL clear the write counter cnt to 0 and clear err.
REQ-019 s_ready SHALL equal (state == LOAD), decoded from registered state only, with no dependence on s_valid.
REQ-020 A beat is accepted when s_valid && s_ready at a rising clk edge; no beat is accepted outside LOAD.
REQ-021 Each accepted beat k SHALL produce, on the next cycle only, ram_en=1, ram_we=1, ram_addr=k, ram_di=reduced(s_data); latency is 1 cycle, with registered outputs.
REQ-022 In cycles with no accepted beat in the previous cycle, ram_en=0 and ram_we=0; ram_addr and ram_di SHALL hold their last values.
REQ-023 Reduction: s_data < Q -> s_data; Q <= s_data < 2Q -> s_data - Q; s_data >= 2Q -> 0 with err set to 1.
REQ-024 ram_di[15:12] SHALL always be 0 for reduced values.
REQ-025 cnt SHALL increment by 1 per accepted beat; an s_valid gap SHALL stall without writes and without advancing cnt.
REQ-026 On acceptance of beat DEPTH-1, the next state SHALL be DONE, so the final write and the DONE cycle coincide.
REQ-027 In DONE, done=1 for exactly one cycle, s_ready=0, then state -> IDLE.
REQ-028 start asserted in the DONE cycle SHALL be ignored; a new load requires start in IDLE.
REQ-029 err SHALL remain asserted after done until the next entry into LOAD.
REQ-030 Exactly DEPTH writes SHALL occur per load, to addresses 0..DEPTH-1 in ascending order, with no wrap-around.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, cnt=0, s_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0, done=0, err=0, busy=0.
REQ-032 Reset mid-LOAD SHALL abort the load with no further RAM writes; RAM contents already written are undefined for the consumer.
REQ-033 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 Full load: start, then 128 back-to-back beats with data = i -> writes addr i, di i in cycles 2..129 after start; done pulses with the addr 127 write; RAM readback of every address equals its index.
REQ-035 Reduction: beats 3328, 3329, 6657, 6658 -> di 3328, 0, 3328, 0; err=1 only after the 6658 beat and held through done.
REQ-036 Stalls: s_valid toggled 1,0,0,1 pattern -> ram_we only one cycle after each accepted beat; addresses stay contiguous; done after the 128th accepted beat.
REQ-037 Ignored start: start pulsed during LOAD and in the DONE cycle -> no counter reset, and the block returns to IDLE.
REQ-038 Reset abort: rst_n low after beat 40 -> all outputs at reset values in the same cycle; a new start reloads from addr 0 with err=0.
